// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: N-way round-robin arbiter with registered one-hot grant,
// ack handshake, and bounded burst locking.
module rr_arbiter_param #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic             ack,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [7:0]       hold_cnt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [0:0] {S_IDLE, S_GRANT} state_t;

    state_t             r_state;
    logic [N-1:0]       r_grant;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_hold;
    logic [IDX_W-1:0]   r_ptr;

    state_t             w_next_state;
    logic               w_next_valid;
    logic [IDX_W-1:0]   w_next_idx;
    logic [CNT_W-1:0]   w_next_hold;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [N-1:0]       w_next_grant;
    logic [IDX_W-1:0]   w_rel_ptr;
    logic [N-1:0]       w_others;
    logic               w_h_req;
    logic               w_h_lock;
    logic               w_can_extend;

    // Lowest set bit of vec (fixed-priority picker); 0 if vec is empty.
    function automatic logic [IDX_W-1:0] f_first(input logic [N-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Round-robin pick: masked picker (bits >= ptr) first, else unmasked.
    function automatic logic [IDX_W-1:0] f_arb(input logic [N-1:0] vec,
                                               input logic [IDX_W-1:0] ptr);
        logic [N-1:0] mask;
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = (IDX_W'(i) >= ptr);
        end
        if (|(vec & mask)) return f_first(vec & mask);
        return f_first(vec);
    endfunction

    // Holder status and release-time arbitration inputs.
    always_comb begin
        w_h_req      = req[r_idx];
        w_h_lock     = lock[r_idx];
        w_rel_ptr    = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + IDX_W'(1);
        w_others     = req & ~(N'(1) << r_idx);
        w_can_extend = ((9'(r_hold) + 9'd1) < 9'(MAX_HOLD));
    end

    // Next-state and next-output logic.
    always_comb begin
        w_next_state = r_state;
        w_next_valid = r_valid;
        w_next_idx   = r_idx;
        w_next_hold  = r_hold;
        w_next_ptr   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_next_state = S_GRANT;
                    w_next_valid = 1'b1;
                    w_next_idx   = f_arb(req, r_ptr);
                    w_next_hold  = '0;
                end
            end
            S_GRANT: begin
                if (ack && w_h_lock && w_h_req && w_can_extend) begin
                    w_next_hold = r_hold + CNT_W'(1);
                end else if (ack || !w_h_req) begin
                    w_next_ptr  = w_rel_ptr;
                    w_next_hold = '0;
                    if (|w_others) begin
                        w_next_idx = f_arb(w_others, w_rel_ptr);
                    end else if (!w_h_req) begin
                        // Nobody left requesting: go idle.
                        w_next_state = S_IDLE;
                        w_next_valid = 1'b0;
                        w_next_idx   = '0;
                    end
                    // Sole requester keeps the grant for a fresh burst.
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_valid = 1'b0;
                w_next_idx   = '0;
                w_next_hold  = '0;
            end
        endcase
        w_next_grant = w_next_valid ? (N'(1) << w_next_idx) : '0;
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_hold  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_valid <= w_next_valid;
            r_idx   <= w_next_idx;
            r_hold  <= w_next_hold;
            r_ptr   <= w_next_ptr;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;
    assign hold_cnt    = r_hold;

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- Parametrised N-way round-robin arbiter with a registered one-hot grant, an acknowledge handshake and optional bounded grant locking.
- Successor to the team's fixed 4-way masked-priority arbiter. Adds:
  - generic requester count
  - grant held until the downstream acknowledges
  - burst lock with a maximum hold limit
  - explicit rotating-priority pointer
- Sits between N request sources and one shared resource, such as an accumulator input port or a memory port.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- MAX_HOLD, 4, maximum consecutive acknowledged transfers one requester may take under lock; legal range 1..255.
- IDX_W, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N  request vector; bit i is requester i.
- lock  input  N  lock bit i: requester i asks to keep the grant after its next ack.
- ack  input  1  downstream completed one transfer for the current grant.
- grant  output  N  registered one-hot grant; all zero when idle.
- grant_valid  output  1  high when grant is nonzero.
- grant_idx  output  IDX_W  binary index of the granted requester; 0 when idle.
- hold_cnt  output  8  acknowledged transfers completed by the current grant holder; 0 when idle.

Behaviour:
- Reset, asynchronous on rst_n low:
  - grant=0, grant_valid=0, grant_idx=0, hold_cnt=0
  - state=IDLE
  - priority pointer ptr=0, so requester 0 has highest priority first.
- Arbitration function:
  - Choose the first set bit of req searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1, with the search wrapping modulo N.
  - Implement as masked and unmasked fixed-priority pickers. Use the masked result if the masked request vector is nonzero, else the unmasked result.
- State IDLE:
  - If req is nonzero, the winner is registered and grant appears on the next cycle (1-cycle latency, req to grant).
  - Go to GRANT with hold_cnt=0.
- State GRANT (holder h):
  - grant stays stable every cycle until a release condition.
  - ack high, lock[h]=1, req[h]=1 and hold_cnt+1 < MAX_HOLD: stay in GRANT with the same holder; hold_cnt increments; ptr unchanged.
  - ack high otherwise (lock low, req dropped, or limit reached): release.
  - req[h] low with ack low (abandon): release.
- Release, in the same cycle as the release condition:
  - ptr <= (h+1) mod N.
  - Re-arbitrate using the new ptr over the current req with bit h excluded.
  - If any other requester wins, the next cycle shows its grant with no idle bubble; hold_cnt=0.
  - If bit h is the only request, grant h again for a fresh burst with hold_cnt=0; this keeps a sole requester from being starved by its own release.
  - If req is all zero, return to IDLE; grant=0 next cycle.
- Outputs derived from state:
  - grant_valid = |grant.
  - grant_idx and hold_cnt are registered together with grant.
  - All outputs change only on a clk edge or on rst_n assertion.
- ack while IDLE is ignored; no state change.
- lock bits of non-holders are ignored.
- MAX_HOLD=1: every ack releases; behaviour is plain round-robin.
- hold_cnt never exceeds MAX_HOLD-1.
- Fairness: with all N requesting and no lock, grants rotate 0,1,...,N-1,0 on successive acks.
- Reset asserted mid-grant: grant drops immediately and asynchronously; ptr returns to 0.

Test Plan:
- Reset and first grant: N=4, release rst_n, req=4'b1010 -> grant=4'b0010 one cycle later, grant_idx=1, hold_cnt=0.
- Rotation: req=4'b1111, lock=0, ack every cycle -> grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycle between grants.
- Burst lock limit: MAX_HOLD=3, req=4'b0011, lock[0]=1, holder 0, three acks:
  - hold_cnt goes 0, 1, 2.
  - The third ack releases; grant=4'b0010 on the next cycle.
- Abandon: holder 2, req[2] drops with ack=0 -> next cycle grant=4'b1000 if req[3]=1, or grant=0 with grant_valid=0 if req is all zero.
- Sole requester re-grant: req=4'b0100 only, lock=0, ack -> grant stays 4'b0100 with hold_cnt back to 0; ptr advances to 3.
- Async reset mid-burst: holder 1 with hold_cnt=2, rst_n low between edges -> grant=0 and hold_cnt=0 immediately; after release, req=4'b1111 -> grant=4'b0001.
